ila_checker: RTL
================

Name: ila_checker

Overview:
- RX-side link-layer block that monitors the initial lane alignment (ILA) sequence arriving after code group synchronisation.
- Tracks multiframe boundaries and checks the K28.0/K28.3/K28.4 control characters.
- Captures the 14 link configuration octets, verifies FCHK and compares key fields against register values.
- Flags the start of user data; sits between the 8b/10b decoder/CGS logic and the RX transport layer.

Parameters:
- MAX_MF_OCTETS, 1024, upper bound on (F+1)*(K+1); sets the octet counter width to 11 bits.

Ports:
- clk  input  1  character clock
- rst_n  input  1  reset, asynchronous, active-low
- i_seq_start  input  1  level; high = CGS complete, expect ILA; low = sync lost
- i_data  input  8  decoded octet, HGFEDCBA
- i_k  input  1  i_data is a control character
- i_vld  input  1  octet valid
- i_ila_multiframe_length  input  8  ILA multiframes minus 1
- i_F  input  8  octets per frame minus 1
- i_K  input  5  frames per multiframe minus 1
- i_L  input  5  expected L (encoded)
- i_LID  input  5  expected lane ID
- o_cfg  output  112  captured config octets; octet n at [8n+7:8n]
- o_cfg_vld  output  1  level; o_cfg complete
- o_ila_done  output  1  1-cycle pulse at ILA end
- o_data  output  8  user data, 1-cycle latency
- o_vld  output  1  user data valid
- o_err_seq  output  1  sticky control-character/sequence error
- o_err_fchk  output  1  sticky FCHK mismatch
- o_err_cfg  output  1  sticky L/F/K/LID mismatch

Behaviour:
- Reset: state IDLE; all outputs 0; o_cfg 0; counters 0.
- MF = (F+1)*(K+1) octets, computed into 11 bits. Counters oct_in_mf (0..MF-1) and mf_cnt (8 bits) advance only when i_vld=1; i_vld=0 freezes all state.
- IDLE: on i_seq_start=1, clear o_cfg, o_cfg_vld and all error flags, then go to WAIT_R.
- WAIT_R: discard K28.5 (0xBC, k=1). First K28.0 (0x1C, k=1) enters ILA with oct_in_mf=1, mf_cnt=0. Any other valid octet sets o_err_seq and the block stays in WAIT_R.
- ILA, per valid octet:
  - oct_in_mf==0 must be K28.0 with k=1.
  - oct_in_mf==MF-1 must be K28.3 (0x7C) with k=1.
  - In mf_cnt==1: oct 1 must be K28.4 (0x9C) with k=1; octs 2..15 must have k=0 and are stored to o_cfg octet (oct-2).
  - Any violation sets o_err_seq. All other octets are unchecked.
  - On the last octet of multiframe i_ila_multiframe_length, go to DATA and pulse o_ila_done on the next cycle.
- Config check: o_cfg_vld rises the cycle after config octet 13 is stored. In that same cycle:
  - o_err_fchk = (FCHK != field sum mod 256). Fields summed: DID, ADJCNT[7:4], BID[3:0], ADJDIR[6], PHADJ[5], LID[4:0], SCR[7], L[4:0], F, K[4:0], M, CS[7:6], N[4:0], SUBCLASSV[7:5], N'[4:0], JESDV[7:5], S[4:0], HD[7], CF[4:0]. Octets 11 and 12 are reserved and not summed.
  - o_err_cfg = L, F, K or LID differs from the corresponding input.
- DATA: o_data <= i_data and o_vld <= i_vld, registered.
  - Any k=1 octet sets o_err_seq. The octet is still forwarded.
- i_seq_start low in any state: return to IDLE next cycle, o_vld=0, no o_ila_done pulse. Error flags and o_cfg hold until the next start.
- MF<17 (config cannot fit): o_err_seq set on entry to ILA. Sequencing continues and o_cfg_vld never rises.
- i_ila_multiframe_length==0: ILA ends after multiframe 0. No config is captured, o_cfg_vld stays 0, and this is not an error.
- Reset mid-ILA: immediate return to the reset state.

Decomposition:
- Shared package jesd204_link_pkg:
  - K28_0/K28_3/K28_4/K28_5 constants.
  - LINK_CONF_OCTET_NUM=14.
  - Config octet indices/bit-field positions, shared with the TX ILA generator.
  - Encoding for the state enum.
- Sub-module ila_fchk_calc: combinational field extraction plus mod-256 sum over the 112-bit config. Reusable by the TX side.

Test Plan:
- F=1,K=15 (MF=32), length=3, clean ILA with correct FCHK, L/F/K/LID matching -> o_cfg_vld high after MF1 oct15; o_ila_done pulses once after 128 ILA octets; all errors 0; the next data octet 0x5A appears on o_data one cycle later.
- Same as above with FCHK octet +1 -> o_err_fchk=1, o_err_seq=0, ILA still completes.
- K28.3 replaced by data 0x7C with k=0 at end of MF2 -> o_err_seq=1 sticky through DATA.
- i_vld low for 5 cycles inside MF1 config -> counters freeze; o_cfg identical to the no-stall run.
- i_seq_start dropped mid-MF2 -> IDLE next cycle, no o_ila_done; re-assert -> errors cleared, full ILA passes.
- Expected LID=3, received LID=4 -> o_err_cfg=1 with o_cfg_vld; o_err_fchk=0 when FCHK is consistent with the received octets.

Source files
------------

// File: rtl/jesd204_link_pkg.sv
// JESD204 link-layer constants shared by the RX ILA checker and the TX ILA generator:
// control characters, link configuration octet layout and the ILA state encoding.
package jesd204_link_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config follows
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma

  localparam int LINK_CONF_OCTET_NUM = 14;
  localparam int CFG_W               = 8 * LINK_CONF_OCTET_NUM;
  localparam int CFG_FIRST_OCT       = 2;
  localparam int CFG_LAST_OCT        = CFG_FIRST_OCT + LINK_CONF_OCTET_NUM - 1;
  localparam int CFG_MIN_MF          = CFG_LAST_OCT + 2;

  localparam int OCT_DID      = 0;
  localparam int OCT_ADJ_BID  = 1;
  localparam int OCT_LID      = 2;
  localparam int OCT_SCR_L    = 3;
  localparam int OCT_F        = 4;
  localparam int OCT_K        = 5;
  localparam int OCT_M        = 6;
  localparam int OCT_CS_N     = 7;
  localparam int OCT_SUBV_NP  = 8;
  localparam int OCT_JESDV_S  = 9;
  localparam int OCT_HD_CF    = 10;
  localparam int OCT_RSVD0    = 11;
  localparam int OCT_FCHK     = 13;

  localparam int FIELD5_W      = 5;  // LID, L, K, N, N', S, CF
  localparam int ADJCNT_LSB    = 4;
  localparam int ADJDIR_BIT    = 6;
  localparam int PHADJ_BIT     = 5;
  localparam int SCR_BIT       = 7;
  localparam int CS_LSB        = 6;
  localparam int SUBCLASSV_LSB = 5;
  localparam int JESDV_LSB     = 5;
  localparam int HD_BIT        = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_R = 2'd1,
    ST_ILA    = 2'd2,
    ST_DATA   = 2'd3
  } ila_state_e;

endpackage

// File: rtl/ila_fchk_calc.sv
// Link configuration checksum: mod-256 sum of the configuration fields in octets 0..10.
// Purely combinational so the TX generator can reuse it on its own config vector.
module ila_fchk_calc
  import jesd204_link_pkg::*;
(
  input  logic [CFG_W-1:0] cfg,
  output logic [7:0]       fchk
);

  logic [7:0] did, f_oct, m_oct;
  logic [3:0] adjcnt, bid;
  logic       adjdir, phadj, scr, hd;
  logic [1:0] cs;
  logic [2:0] subclassv, jesdv;
  logic [FIELD5_W-1:0] lid, l, k, n, np, s, cf;
  logic unused_bits;

  assign did       = cfg[8*OCT_DID +: 8];
  assign adjcnt    = cfg[8*OCT_ADJ_BID + ADJCNT_LSB +: 4];
  assign bid       = cfg[8*OCT_ADJ_BID +: 4];
  assign adjdir    = cfg[8*OCT_LID + ADJDIR_BIT];
  assign phadj     = cfg[8*OCT_LID + PHADJ_BIT];
  assign lid       = cfg[8*OCT_LID +: FIELD5_W];
  assign scr       = cfg[8*OCT_SCR_L + SCR_BIT];
  assign l         = cfg[8*OCT_SCR_L +: FIELD5_W];
  assign f_oct     = cfg[8*OCT_F +: 8];
  assign k         = cfg[8*OCT_K +: FIELD5_W];
  assign m_oct     = cfg[8*OCT_M +: 8];
  assign cs        = cfg[8*OCT_CS_N + CS_LSB +: 2];
  assign n         = cfg[8*OCT_CS_N +: FIELD5_W];
  assign subclassv = cfg[8*OCT_SUBV_NP + SUBCLASSV_LSB +: 3];
  assign np        = cfg[8*OCT_SUBV_NP +: FIELD5_W];
  assign jesdv     = cfg[8*OCT_JESDV_S + JESDV_LSB +: 3];
  assign s         = cfg[8*OCT_JESDV_S +: FIELD5_W];
  assign hd        = cfg[8*OCT_HD_CF + HD_BIT];
  assign cf        = cfg[8*OCT_HD_CF +: FIELD5_W];

  assign fchk = did + 8'(adjcnt) + 8'(bid) + 8'(adjdir) + 8'(phadj) + 8'(lid)
              + 8'(scr) + 8'(l) + f_oct + 8'(k) + m_oct + 8'(cs) + 8'(n)
              + 8'(subclassv) + 8'(np) + 8'(jesdv) + 8'(s) + 8'(hd) + 8'(cf);

  // Reserved bits, reserved octets 11/12 and FCHK itself take no part in the sum.
  assign unused_bits = ^{cfg[8*OCT_LID + 7], cfg[8*OCT_SCR_L + 5 +: 2],
                         cfg[8*OCT_K + 5 +: 3], cfg[8*OCT_CS_N + 5],
                         cfg[8*OCT_HD_CF + 5 +: 2], cfg[CFG_W-1:8*OCT_RSVD0]};

endmodule

// File: rtl/ila_checker.sv
// RX initial lane alignment checker: follows multiframes, checks /R/ /Q/ /A/ placement,
// captures and checks the link configuration, then forwards user data.
module ila_checker
  import jesd204_link_pkg::*;
#(
  parameter int MAX_MF_OCTETS = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_seq_start,
  input  logic [7:0]       i_data,
  input  logic             i_k,
  input  logic             i_vld,
  input  logic [7:0]       i_ila_multiframe_length,
  input  logic [7:0]       i_F,
  input  logic [4:0]       i_K,
  input  logic [4:0]       i_L,
  input  logic [4:0]       i_LID,
  output logic [CFG_W-1:0] o_cfg,
  output logic             o_cfg_vld,
  output logic             o_ila_done,
  output logic [7:0]       o_data,
  output logic             o_vld,
  output logic             o_err_seq,
  output logic             o_err_fchk,
  output logic             o_err_cfg
);

  localparam int OCT_W = $clog2(MAX_MF_OCTETS) + 1;

  ila_state_e state, state_nxt;

  logic [OCT_W-1:0] oct_in_mf, mf_octets, mf_last;
  logic [7:0]       mf_cnt;
  logic [3:0]       cfg_idx;
  logic [7:0]       fchk_sum;
  logic [7:0]       rx_f;
  logic [4:0]       rx_lid, rx_l, rx_k;
  logic is_k28_0, is_k28_3, is_k28_4, is_k28_5;
  logic mf_end, ila_last, in_cfg_oct, cfg_short, ila_viol, cfg_mismatch;
  logic cfg_full_p1;

  assign mf_octets = (OCT_W'(i_F) + OCT_W'(1)) * (OCT_W'(i_K) + OCT_W'(1));
  assign mf_last   = mf_octets - OCT_W'(1);
  assign cfg_short = (mf_octets < OCT_W'(CFG_MIN_MF));

  assign is_k28_0 = i_k && (i_data == K28_0);
  assign is_k28_3 = i_k && (i_data == K28_3);
  assign is_k28_4 = i_k && (i_data == K28_4);
  assign is_k28_5 = i_k && (i_data == K28_5);

  assign mf_end     = (oct_in_mf == mf_last);
  assign ila_last   = mf_end && (mf_cnt == i_ila_multiframe_length);
  assign in_cfg_oct = (mf_cnt == 8'd1) && (oct_in_mf >= OCT_W'(CFG_FIRST_OCT))
                   && (oct_in_mf <= OCT_W'(CFG_LAST_OCT));
  assign cfg_idx    = 4'(oct_in_mf - OCT_W'(CFG_FIRST_OCT));

  assign ila_viol = ((oct_in_mf == '0) && !is_k28_0)
                 || (mf_end && !is_k28_3)
                 || ((mf_cnt == 8'd1) && (oct_in_mf == OCT_W'(1)) && !is_k28_4)
                 || (in_cfg_oct && i_k);

  assign rx_lid = o_cfg[8*OCT_LID +: FIELD5_W];
  assign rx_l   = o_cfg[8*OCT_SCR_L +: FIELD5_W];
  assign rx_f   = o_cfg[8*OCT_F +: 8];
  assign rx_k   = o_cfg[8*OCT_K +: FIELD5_W];
  assign cfg_mismatch = (rx_lid != i_LID) || (rx_l != i_L) || (rx_f != i_F) || (rx_k != i_K);

  ila_fchk_calc u_fchk (
    .cfg  (o_cfg),
    .fchk (fchk_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_seq_start) state_nxt = ST_WAIT_R;
      ST_WAIT_R: if (i_vld && is_k28_0) state_nxt = ST_ILA;
      ST_ILA:    if (i_vld && ila_last) state_nxt = ST_DATA;
      default:   state_nxt = state;
    endcase
    if (!i_seq_start) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oct_in_mf   <= '0;
      mf_cnt      <= '0;
      cfg_full_p1 <= 1'b0;
      o_cfg       <= '0;
      o_cfg_vld   <= 1'b0;
      o_ila_done  <= 1'b0;
      o_data      <= '0;
      o_vld       <= 1'b0;
      o_err_seq   <= 1'b0;
      o_err_fchk  <= 1'b0;
      o_err_cfg   <= 1'b0;
    end else begin
      o_ila_done  <= 1'b0;
      o_vld       <= 1'b0;
      cfg_full_p1 <= 1'b0;
      // Stage p1: whole config vector registered, evaluate FCHK and field match
      if (cfg_full_p1) begin
        o_cfg_vld <= 1'b1;
        if (fchk_sum != o_cfg[8*OCT_FCHK +: 8]) o_err_fchk <= 1'b1;
        if (cfg_mismatch) o_err_cfg <= 1'b1;
      end
      if (i_seq_start) begin
        case (state)
          ST_IDLE: begin
            o_cfg      <= '0;
            o_cfg_vld  <= 1'b0;
            o_err_seq  <= 1'b0;
            o_err_fchk <= 1'b0;
            o_err_cfg  <= 1'b0;
          end
          ST_WAIT_R: if (i_vld) begin
            if (is_k28_0) begin
              oct_in_mf <= OCT_W'(1);
              mf_cnt    <= '0;
              if (cfg_short) o_err_seq <= 1'b1;
            end else if (!is_k28_5) begin
              o_err_seq <= 1'b1;
            end
          end
          ST_ILA: if (i_vld) begin
            if (ila_viol) o_err_seq <= 1'b1;
            if (in_cfg_oct) o_cfg[{cfg_idx, 3'b000} +: 8] <= i_data;
            if (in_cfg_oct && (cfg_idx == 4'(LINK_CONF_OCTET_NUM - 1)) && !cfg_short)
              cfg_full_p1 <= 1'b1;
            if (mf_end) begin
              oct_in_mf <= '0;
              mf_cnt    <= mf_cnt + 8'd1;
            end else begin
              oct_in_mf <= oct_in_mf + OCT_W'(1);
            end
            if (ila_last) o_ila_done <= 1'b1;
          end
          default: begin
            o_data <= i_data;
            o_vld  <= i_vld;
            if (i_vld && i_k) o_err_seq <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
